// File: rtl/bit_serializer_if.sv
// Load handshake and serial output bundle for bit_serializer.
// master = word producer / bit consumer side, slave = the serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             out;
    logic             out_valid;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  out,
        input  out_valid
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output out,
        output out_valid
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-in serial-out streamer feeding a bit-serial detector; one bit per clock.
// Optional one-word prefetch buffer enabled by defining BIT_SERIALIZER_PREFETCH_EN.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    bit_serializer_if.slave   bus,
    output logic              state_dbg
);
    // Handshake: a word transfers on a rising edge where load_valid and
    // load_ready are both high; data_in is only sampled on that edge.

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             accept;
    logic             load_en;
    logic [WIDTH-1:0] load_word;
    logic             last_bit;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    assign last_bit  = (state == SHIFT) && (cnt == LAST);
    assign accept    = bus.load_valid && bus.load_ready;
    assign state_dbg = (state == SHIFT);

`ifdef BIT_SERIALIZER_PREFETCH_EN
    logic [WIDTH-1:0] pbuf;
    logic             pbuf_full;
    logic             fill_buf;
    logic             drain_buf;

    assign bus.load_ready = !rst && !pbuf_full;

    always_comb begin
        load_en   = 1'b0;
        load_word = bus.data_in;
        fill_buf  = 1'b0;
        drain_buf = 1'b0;
        if (state == IDLE) begin
            load_en = accept;
        end else if (last_bit) begin
            // A buffered word has priority; ready is low while it is full.
            if (pbuf_full) begin
                load_en   = 1'b1;
                load_word = pbuf;
                drain_buf = 1'b1;
            end else begin
                load_en = accept;
            end
        end else begin
            fill_buf = accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pbuf      <= '0;
            pbuf_full <= 1'b0;
        end else if (fill_buf) begin
            pbuf      <= bus.data_in;
            pbuf_full <= 1'b1;
        end else if (drain_buf) begin
            pbuf_full <= 1'b0;
        end
    end
`else
    assign bus.load_ready = !rst && (state == IDLE);

    always_comb begin
        load_en   = 1'b0;
        load_word = bus.data_in;
        if (state == IDLE) begin
            load_en = accept;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            sreg          <= '0;
            bus.out       <= IDLE_BIT;
            bus.out_valid <= 1'b0;
        end else if (load_en) begin
            state         <= SHIFT;
            sreg          <= load_word;
            cnt           <= '0;
            bus.out       <= first_bit(load_word);
            bus.out_valid <= 1'b1;
        end else if (state == SHIFT && !last_bit) begin
            // The output end of sreg already shows on out; present its neighbour.
            if (MSB_FIRST != 0) begin
                sreg    <= {sreg[WIDTH-2:0], 1'b0};
                bus.out <= sreg[WIDTH-2];
            end else begin
                sreg    <= {1'b0, sreg[WIDTH-1:1]};
                bus.out <= sreg[1];
            end
            cnt <= cnt + CW'(1);
        end else if (state == SHIFT) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out       <= IDLE_BIT;
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first 8-bit instance with a bit
// scoreboard, plus a 4-bit LSB-first instance checked step by step.
module tb_bit_serializer;
    localparam int W = 1;

`ifdef BIT_SERIALIZER_PREFETCH_EN
    localparam int GAP = 0;
`else
    localparam int GAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_a;
    logic dbg_b;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic         vlog[$];
    logic         mon_en = 1'b0;
    logic         log_en = 1'b0;

    bit_serializer_if #(.WIDTH(8)) bus_a ();
    bit_serializer_if #(.WIDTH(4)) bus_b ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_a),
        .state_dbg (dbg_a)
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_b),
        .state_dbg (dbg_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // scoreboard: every valid bit pops one expected bit, idle cycles show IDLE_BIT
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (log_en) vlog.push_back(bus_a.out_valid);
            if (bus_a.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 32'(bus_a.out), 32'hFFFF_FFFF);
                end else begin
                    check("data_bit", 32'(bus_a.out), 32'(exp_q.pop_front()));
                end
            end else begin
                check("idle_bit", 32'(bus_a.out), 32'(1'b0));
            end
        end
    end

    // driver: call at a negedge; returns at the negedge after the accept edge
    task automatic send_a(input logic [7:0] w, output int waits);
        bus_a.data_in    = w;
        bus_a.load_valid = 1'b1;
        waits = 0;
        while (!bus_a.load_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 100) begin
            check("accept_timeout", 32'(0), 32'(1));
            bus_a.load_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        @(negedge clk);
    endtask

    task automatic drain_a(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int w1, w2, w3;
        int i, run1, gap, run2;
        logic [3:0] wb;

        bus_a.data_in    = '0;
        bus_a.load_valid = 1'b0;
        bus_b.data_in    = '0;
        bus_b.load_valid = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready_a", 32'(bus_a.load_ready), 32'(0));
        check("rst_ready_b", 32'(bus_b.load_ready), 32'(0));
        check("rst_out", 32'(bus_a.out), 32'(0));
        check("rst_valid", 32'(bus_a.out_valid), 32'(0));
        check("rst_state", 32'(dbg_a), 32'(0));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus_a.load_ready), 32'(1));
        mon_en = 1'b1;

        // idle for 10 cycles
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_ready", 32'(bus_a.load_ready), 32'(1));
            check("idle_valid", 32'(bus_a.out_valid), 32'(0));
        end

        // single word
        send_a(8'hB0, w1);
        bus_a.load_valid = 1'b0;
        drain_a("single_drain");

        // back-to-back with load_valid held high
        vlog.delete();
        log_en = 1'b1;
        send_a(8'hB5, w1);
        send_a(8'h6D, w2);
        bus_a.load_valid = 1'b0;
        check("b2b_wait", 32'(w2), 32'((GAP != 0) ? 8 : 0));
        drain_a("b2b_drain");
        repeat (2) @(negedge clk);
        log_en = 1'b0;
        i = 0; run1 = 0; gap = 0; run2 = 0;
        while (i < vlog.size() && !vlog[i]) i++;
        while (i < vlog.size() && vlog[i]) begin run1++; i++; end
        while (i < vlog.size() && !vlog[i] && gap < 50) begin gap++; i++; end
        while (i < vlog.size() && vlog[i]) begin run2++; i++; end
        check("b2b_run1", 32'(run1), 32'(8));
        check("b2b_gap", 32'(gap), 32'(GAP));
        check("b2b_run2", 32'(run2), 32'(8));

`ifdef BIT_SERIALIZER_PREFETCH_EN
        // buffer fills mid-word; a third word waits for the transfer
        send_a(8'h3C, w1);
        send_a(8'hA5, w2);
        check("pf_fill_wait", 32'(w2), 32'(0));
        send_a(8'h96, w3);
        bus_a.load_valid = 1'b0;
        check("pf_full_wait", 32'(w3), 32'(7));
        drain_a("pf_drain");
`endif

        // reset mid-word after three bits
        send_a(8'hFF, w1);
        bus_a.load_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out", 32'(bus_a.out), 32'(0));
        check("midrst_valid", 32'(bus_a.out_valid), 32'(0));
        check("midrst_ready", 32'(bus_a.load_ready), 32'(0));
        check("midrst_state", 32'(dbg_a), 32'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_release_ready", 32'(bus_a.load_ready), 32'(1));
        mon_en = 1'b1;
        @(negedge clk);
        send_a(8'h5A, w1);
        bus_a.load_valid = 1'b0;
        drain_a("post_rst_drain");

        // 4-bit LSB-first instance
        wb = 4'b1101;
        bus_b.data_in    = wb;
        bus_b.load_valid = 1'b1;
        check("b_ready", 32'(bus_b.load_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        bus_b.load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("b_bit", 32'(bus_b.out), 32'(wb[k]));
            check("b_valid", 32'(bus_b.out_valid), 32'(1));
            @(negedge clk);
        end
        check("b_end_valid", 32'(bus_b.out_valid), 32'(0));
        check("b_end_out", 32'(bus_b.out), 32'(0));
        check("b_end_ready", 32'(bus_b.load_ready), 32'(1));

        repeat (3) @(negedge clk);
        check("final_queue", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-in, serial-out bit streamer that sits directly upstream of the 1011 Mealy sequence detector and drives its one-bit `in` port. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock, MSB-first by default. Between words it drives a defined idle bit, because the detector samples every cycle. A qualifying `out_valid` marks real data bits.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 emitted first; 0 = bit 0 emitted first.
- `IDLE_BIT`, 0: value driven on `out` whenever `out_valid` = 0.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `data_in`  input  WIDTH  word to serialize; sampled only on an accepted load.
- `load_valid`  input  1  producer has a word on `data_in`.
- `load_ready`  output  1  block can accept a word this cycle.
- `out`  output  1  serial bit to the detector `in`; registered.
- `out_valid`  output  1  `out` carries a data bit; registered.

## Operation
- Accept happens on a rising edge where `load_valid` = 1 and `load_ready` = 1. `data_in` must be stable in that cycle.
- FSM states:
  - IDLE: no word in the shift register.
  - SHIFT: emitting a word.
- Bit counter `cnt`, width clog2(WIDTH).
- IDLE -> SHIFT on accept:
  - Shift register loads `data_in`.
  - `cnt` is set to 0.
  - `out` takes the first bit.
  - `out_valid` is set to 1.
- In SHIFT with `cnt` < WIDTH-1: each edge shifts by one toward the output end, increments `cnt` and presents the next bit.
- In SHIFT with `cnt` = WIDTH-1 (last bit showing):
  - If a next word is available, load it exactly as in an accept.
  - Otherwise go to IDLE, with `out` = IDLE_BIT and `out_valid` = 0.
- The counter never wraps past WIDTH-1. A word is never emitted partially unless reset intervenes.
- `load_ready` is combinational from state.
  - It is forced to 0 while `rst` is high.
  - Without the prefetch option, it is 1 only in IDLE.
- Reset values, asynchronous:
  - State is IDLE, `cnt` is 0 and the shift register is 0.
  - `out` = IDLE_BIT and `out_valid` = 0.
  - The prefetch buffer, when present, is empty.
  - `load_ready` goes to 1 from the first cycle after `rst` falls.
- Reset mid-word: the word is discarded and `out` returns to IDLE_BIT immediately. No bits of it appear after reset.

## Timing
- Accept at edge k:
  - Bit 0 of the sequence appears on `out` after edge k.
  - Bit i appears after edge k+i.
  - The last bit is held until edge k+WIDTH.
- Latency from accept to first bit on `out` is 1 edge. `out_valid` stays high for exactly WIDTH consecutive cycles per word.
- Without the prefetch option, back-to-back words are separated by exactly 1 cycle of `out` = IDLE_BIT with `out_valid` = 0.
  - The state is IDLE after edge k+WIDTH.
  - The earliest next accept is edge k+WIDTH+1.
- The detector sees the data stream with the fixed 1-cycle registered delay of this block.

## Configuration
- `BIT_SERIALIZER_PREFETCH_EN` defined: adds a one-entry holding buffer.
  - `load_ready` = buffer empty, in any state.
  - Accept in IDLE, or on the last-bit edge with the buffer empty, bypasses straight into the shift register.
  - Accept during SHIFT otherwise fills the buffer.
  - On the last-bit edge a full buffer transfers to the shift register and the buffer empties.
  - Consecutive words stream with zero gap cycles.
- Not defined: no buffer, and `load_ready` is high only in IDLE. Gap behaviour is as in Timing.

## Test plan
- Reset, then one word: WIDTH=8, MSB_FIRST=1, accept 8'hB0 -> `out` = 1,0,1,1,0,0,0,0 on the 8 cycles after accept, with `out_valid` high for those 8 cycles. The detector raises `out` on the 4th bit.
- Idle check: after reset with no loads for 10 cycles -> `out` = IDLE_BIT, `out_valid` = 0 and `load_ready` = 1 throughout. While `rst` is high, `load_ready` = 0.
- Back-to-back: `load_valid` held high with 8'hB5 then 8'h6D.
  - Without the macro: 1 idle cycle between the words.
  - With the macro: 16 contiguous valid bits 1011_0101_0110_1101.
  - In both cases the second word is accepted exactly once.
- Reset mid-word: assert `rst` after 3 bits of 8'hFF -> `out` = 0 and `out_valid` = 0 immediately. After release the next accepted word streams complete, from its first bit.
- WIDTH=4, MSB_FIRST=0: accept 4'b1101 -> `out` = 1,0,1,1 over 4 cycles.
- Prefetch only: load the buffer mid-word, then assert `load_valid` again -> `load_ready` = 0 until the buffer transfers on the last-bit edge, and no word is lost or duplicated.
